// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU front end.
//   ADDR_W / INSTR_W : program-counter and instruction widths
//   RESET_PC         : program counter value after reset
//   fetch_state_t    : fetch sequencer states
//   pc_sel_t         : next-pc selection for pc_reg
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    HALTED
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH
  } pc_sel_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-pc mux.
//   clk, rst      : clock and synchronous active-high reset (loads RESET_PC)
//   pc_sel        : PC_HOLD keeps the value, PC_INC adds one (wraps), PC_BRANCH loads branch_target
//   branch_target : redirect address
//   pc            : current program counter
module pc_reg
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_t           pc_sel,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_reg_q;
  logic [ADDR_W-1:0] pc_next;

  always_comb begin
    pc_next = pc_reg_q;
    case (pc_sel)
      PC_INC:    pc_next = pc_reg_q + ADDR_W'(1);  // truncation gives the modulo wrap
      PC_BRANCH: pc_next = branch_target;
      default:   pc_next = pc_reg_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg_q <= RESET_PC;
    end else begin
      pc_reg_q <= pc_next;
    end
  end

  assign pc = pc_reg_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch sequencer.
//   clk, rst                  : clock, synchronous active-high reset
//   imem_req/imem_addr        : request to instruction memory, held until imem_ack
//   imem_ack/imem_rdata       : one-cycle response from instruction memory
//   instr/instr_pc/instr_valid: fetched word to decode, accepted on instr_ready
//   pc_branch/branch_target   : redirect from the ALU stage
//   halt/halted               : stop fetching (sampled in FETCH) / halted status
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               pc_branch,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic               halted
);

  fetch_state_t       state_reg;
  logic               flush_reg;
  logic               req_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [ADDR_W-1:0]  instr_pc_reg;
  logic               valid_reg;
  logic               halted_reg;

  logic [ADDR_W-1:0]  pc;
  pc_sel_t            pc_sel;
  logic               accept;

  // A branch in HOLD overrides a simultaneous handshake, so no increment then.
  assign accept = (state_reg == HOLD) && valid_reg && instr_ready;

  always_comb begin
    pc_sel = PC_HOLD;
    if (pc_branch) begin
      pc_sel = PC_BRANCH;
    end else if (accept) begin
      pc_sel = PC_INC;
    end
  end

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .pc            (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FETCH;
      flush_reg    <= 1'b0;
      req_reg      <= 1'b0;
      addr_reg     <= '0;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
      valid_reg    <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (halt) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end else if (!pc_branch) begin
            // A branch arriving here only moves the pc; the request goes out
            // next cycle from the new address so imem_addr never needs a flush.
            req_reg   <= 1'b1;
            addr_reg  <= pc;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            req_reg   <= 1'b0;
            flush_reg <= 1'b0;
            if (flush_reg || pc_branch) begin
              state_reg <= FETCH;
            end else begin
              instr_reg    <= imem_rdata;
              instr_pc_reg <= addr_reg;
              valid_reg    <= 1'b1;
              state_reg    <= HOLD;
            end
          end else if (pc_branch) begin
            // Request stays up with its original address; its data is dropped.
            flush_reg <= 1'b1;
          end
        end
        HOLD: begin
          if (pc_branch || instr_ready) begin
            valid_reg <= 1'b0;
            state_reg <= FETCH;
          end
        end
        HALTED: begin
          if (!halt) begin
            halted_reg <= 1'b0;
            state_reg  <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = addr_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = valid_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        pc_branch = 1'b0;
  logic [15:0] branch_target = '0;
  logic        halt = 1'b0;
  logic        halted;

  pc_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc_branch     (pc_branch),
    .branch_target (branch_target),
    .halt          (halt),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } sb_t;

  typedef struct {
    int          lat;
    int          stall;
    logic [15:0] addr;
  } vec_t;

  sb_t  sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   mem_lat = 0;
  int   wait_cnt = 0;
  bit   discard_next = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hBEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: acks after mem_lat extra cycles of a held request.
  task automatic drive_mem();
    imem_ack = 1'b0;
    if (rst || !imem_req) begin
      wait_cnt = 0;
    end else if (wait_cnt >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wait_cnt   = 0;
      if (discard_next) discard_next = 1'b0;
      else sb_q.push_back('{instr: mem_word(imem_addr), pc: imem_addr});
    end else begin
      wait_cnt++;
    end
  endtask

  // One clock; handshakes seen at the edge are popped and checked.
  task automatic tick();
    bit          hs;
    logic [15:0] hi, hp;
    sb_t         e;
    hs = instr_valid && instr_ready && !pc_branch && !rst;
    hi = instr;
    hp = instr_pc;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_instr", {hp, hi}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        $display("xfer pc=%h instr=%h expected pc=%h instr=%h", hp, hi, e.pc, e.instr);
        chk("sb_instr", {16'h0, hi}, {16'h0, e.instr});
        chk("sb_pc", {16'h0, hp}, {16'h0, e.pc});
      end
    end
    drive_mem();
  endtask

  task automatic wait_req(input logic [15:0] exp_addr, output int rise_cyc);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!imem_req && n < 30);
    chk("req_timeout", {31'h0, imem_req}, 32'h1);
    chk("req_addr", {16'h0, imem_addr}, {16'h0, exp_addr});
    rise_cyc = cyc;
  endtask

  task automatic wait_req_drop(input logic [15:0] exp_addr, output int n);
    n = 0;
    while (imem_req && n < 30) begin
      chk("addr_stable", {16'h0, imem_addr}, {16'h0, exp_addr});
      tick();
      n++;
    end
    chk("req_drop_timeout", {31'h0, imem_req}, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, output int rise_cyc);
    int          n;
    logic [15:0] held;
    mem_lat = v.lat;
    instr_ready = 1'b0;
    wait_req(v.addr, rise_cyc);
    wait_req_drop(v.addr, n);
    chk("req_cycles", n, v.lat + 1);
    chk("valid_after_ack", {31'h0, instr_valid}, 32'h1);
    held = instr;
    for (int s = 0; s < v.stall; s++) begin
      tick();
      chk("stall_instr_stable", {16'h0, instr}, {16'h0, held});
      chk("stall_no_req", {31'h0, imem_req}, 32'h0);
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("valid_cleared", {31'h0, instr_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   rise[6];
    int   r, n;

    vecs[0] = '{lat: 0, stall: 0, addr: 16'h0000};
    vecs[1] = '{lat: 0, stall: 0, addr: 16'h0001};
    vecs[2] = '{lat: 0, stall: 0, addr: 16'h0002};
    vecs[3] = '{lat: 4, stall: 0, addr: 16'h0003};
    vecs[4] = '{lat: 0, stall: 5, addr: 16'h0004};
    vecs[5] = '{lat: 1, stall: 2, addr: 16'h0005};

    // Reset state
    repeat (3) tick();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", {16'h0, instr}, 32'h0);
    chk("rst_instr_pc", {16'h0, instr_pc}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    rst = 1'b0;

    // Sequential fetch, delayed ack, decode stall
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], rise[i]);
      if (i > 0) chk("req_spacing", rise[i] - rise[i-1], vecs[i-1].lat + vecs[i-1].stall + 3);
    end

    // Branch during WAIT: late data dropped, refetch from target
    mem_lat = 3;
    wait_req(16'h0006, r);
    tick();
    pc_branch = 1'b1;
    branch_target = 16'h0040;
    discard_next = 1'b1;
    tick();
    pc_branch = 1'b0;
    chk("branch_addr_held", {16'h0, imem_addr}, 32'h0006);
    chk("branch_req_held", {31'h0, imem_req}, 32'h1);
    n = 0;
    while (imem_req && n < 30) begin
      chk("flush_no_valid", {31'h0, instr_valid}, 32'h0);
      tick();
      n++;
    end
    chk("flush_no_valid_end", {31'h0, instr_valid}, 32'h0);
    run_vec('{lat: 0, stall: 0, addr: 16'h0040}, r);

    // Branch in HOLD beats a simultaneous handshake; then pc wrap
    mem_lat = 0;
    wait_req(16'h0041, r);
    tick();
    chk("hold_valid", {31'h0, instr_valid}, 32'h1);
    instr_ready = 1'b1;
    pc_branch = 1'b1;
    branch_target = 16'hFFFF;
    tick();
    instr_ready = 1'b0;
    pc_branch = 1'b0;
    chk("hold_branch_valid", {31'h0, instr_valid}, 32'h0);
    chk("hold_branch_sb", sb_q.size(), 1);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    run_vec('{lat: 0, stall: 0, addr: 16'hFFFF}, r);
    run_vec('{lat: 0, stall: 0, addr: 16'h0000}, r);

    // Halt during WAIT: transfer completes, then halt; branch while halted
    mem_lat = 2;
    wait_req(16'h0001, r);
    halt = 1'b1;
    wait_req_drop(16'h0001, n);
    chk("halt_valid", {31'h0, instr_valid}, 32'h1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    chk("halted_set", {31'h0, halted}, 32'h1);
    chk("halted_no_req", {31'h0, imem_req}, 32'h0);
    pc_branch = 1'b1;
    branch_target = 16'h0100;
    tick();
    pc_branch = 1'b0;
    repeat (2) tick();
    chk("halted_after_branch", {31'h0, halted}, 32'h1);
    chk("halted_no_req2", {31'h0, imem_req}, 32'h0);
    halt = 1'b0;
    tick();
    chk("halted_clear", {31'h0, halted}, 32'h0);
    run_vec('{lat: 0, stall: 0, addr: 16'h0100}, r);

    // Reset mid-WAIT
    mem_lat = 10;
    wait_req(16'h0101, r);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("midrst_req", {31'h0, imem_req}, 32'h0);
    chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
    chk("midrst_instr", {16'h0, instr}, 32'h0);
    chk("midrst_instr_pc", {16'h0, instr_pc}, 32'h0);
    rst = 1'b0;
    run_vec('{lat: 0, stall: 0, addr: 16'h0000}, r);

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
